// File: rtl/cp0_timer_ctrl.sv
// MIPS coprocessor-0: SR/Cause/EPC/PRId/BadVAddr plus Count/Compare timer.
// Resolves interrupts and exceptions combinationally against the M-stage victim and handles ERET.
module cp0_timer_ctrl #(
   parameter int          NUM_HWINT = 6,
   parameter bit          TIMER_EN  = 1'b1,
   parameter logic [31:0] PRID_VAL  = 32'h18373541
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [4:0]           i_rd_addr,
   output logic [31:0]          o_rdata,
   input  logic                 i_wr_en,
   input  logic [4:0]           i_wr_addr,
   input  logic [31:0]          i_wdata,
   input  logic [NUM_HWINT-1:0] i_hw_int,
   input  logic                 i_exc_req,
   input  logic [4:0]           i_exc_code,
   input  logic [31:0]          i_exc_pc,
   input  logic                 i_exc_bd,
   input  logic [31:0]          i_exc_badvaddr,
   input  logic                 i_eret,
   output logic                 o_take_exc,
   output logic [31:0]          o_epc_out
);
   localparam logic [4:0] A_BADVA = 5'd8;
   localparam logic [4:0] A_COUNT = 5'd9;
   localparam logic [4:0] A_CMP   = 5'd11;
   localparam logic [4:0] A_SR    = 5'd12;
   localparam logic [4:0] A_CAUSE = 5'd13;
   localparam logic [4:0] A_EPC   = 5'd14;
   localparam logic [4:0] A_PRID  = 5'd15;

   logic [31:0]          r_sr, r_epc, r_badvaddr, r_count, r_compare;
   logic [1:0]           r_sw;
   logic [4:0]           r_exccode;
   logic                 r_bd, r_ti;
   logic [NUM_HWINT-1:0] r_hw;

   logic [7:0]  w_ip;
   logic [31:0] w_cause, w_victim;
   logic        w_int_pend, w_take, w_wr;

   // IP[1:0] are software bits, IP[2+] track the sampled device lines.
   always_comb begin
      w_ip      = '0;
      w_ip[1:0] = r_sw;
      for (int i = 0; i < NUM_HWINT; i++) w_ip[2+i] = r_hw[i];
      w_ip[7]   = w_ip[7] | (r_ti & TIMER_EN);
   end

   assign w_cause    = {r_bd, 15'b0, w_ip, 1'b0, r_exccode, 2'b00};
   assign w_victim   = i_exc_pc & ~32'h3;
   assign w_int_pend = r_sr[0] & ~r_sr[1] & |(w_ip & r_sr[15:8]);
   assign w_take     = ~reset & (w_int_pend | (i_exc_req & ~r_sr[1]));
   // mtc0 only lands on edges with no exception entry and no ERET.
   assign w_wr       = i_wr_en & ~w_take & ~i_eret;

   assign o_take_exc = w_take;
   assign o_epc_out  = r_epc;

   always_comb begin
      o_rdata = '0;
      case (i_rd_addr)
         A_BADVA: o_rdata = r_badvaddr;
         A_COUNT: o_rdata = r_count;
         A_CMP:   o_rdata = r_compare;
         A_SR:    o_rdata = r_sr;
         A_CAUSE: o_rdata = w_cause;
         A_EPC:   o_rdata = r_epc;
         A_PRID:  o_rdata = PRID_VAL;
         default: o_rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sr       <= '0;
         r_epc      <= '0;
         r_badvaddr <= '0;
         r_count    <= '0;
         r_compare  <= '0;
         r_sw       <= '0;
         r_exccode  <= '0;
         r_bd       <= 1'b0;
         r_ti       <= 1'b0;
         r_hw       <= '0;
      end else begin
         r_hw <= i_hw_int;

         if (w_wr && i_wr_addr == A_COUNT) r_count <= i_wdata;
         else                              r_count <= r_count + 32'd1;

         // A Compare write beats a same-edge match.
         if (w_wr && i_wr_addr == A_CMP) begin
            r_compare <= i_wdata;
            r_ti      <= 1'b0;
         end else if (r_count == r_compare) begin
            r_ti <= 1'b1;
         end

         if (w_take) begin
            r_sr[1]   <= 1'b1;
            r_exccode <= w_int_pend ? 5'd0 : i_exc_code;
            r_bd      <= i_exc_bd;
            r_epc     <= w_victim;
            if (!w_int_pend && (i_exc_code == 5'd4 || i_exc_code == 5'd5))
               r_badvaddr <= i_exc_badvaddr;
         end else if (i_eret) begin
            r_sr[1] <= 1'b0;
         end else if (w_wr) begin
            case (i_wr_addr)
               A_SR:    r_sr  <= i_wdata;
               A_CAUSE: r_sw  <= i_wdata[9:8];
               A_EPC:   r_epc <= {i_wdata[31:2], 2'b00};
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// Bench for cp0_timer_ctrl: directed scenarios plus random traffic against a register-level model.
module tb_cp0_timer_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rd_addr = '0, wr_addr = '0, exc_code = '0;
   logic [31:0] rdata, wdata = '0, exc_pc = '0, exc_badvaddr = '0, epc_out;
   logic        wr_en = 1'b0, exc_req = 1'b0, exc_bd = 1'b0, eret = 1'b0, take_exc;
   logic [5:0]  hw_int = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cp0_timer_ctrl dut (
      .clk(clk), .reset(reset),
      .i_rd_addr(rd_addr), .o_rdata(rdata),
      .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wdata(wdata),
      .i_hw_int(hw_int),
      .i_exc_req(exc_req), .i_exc_code(exc_code), .i_exc_pc(exc_pc),
      .i_exc_bd(exc_bd), .i_exc_badvaddr(exc_badvaddr),
      .i_eret(eret), .o_take_exc(take_exc), .o_epc_out(epc_out)
   );

   // Reference state, kept as architectural fields
   logic [31:0] m_sr = '0, m_epc = '0, m_bva = '0, m_count = '0, m_cmp = '0;
   logic [1:0]  m_sw = '0;
   logic [4:0]  m_code = '0;
   logic        m_bd = 1'b0, m_ti = 1'b0;
   logic [5:0]  m_hw = '0;

   function automatic logic [7:0] m_ip();
      return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
   endfunction

   function automatic logic m_intp();
      return m_sr[0] && !m_sr[1] && ((m_ip() & m_sr[15:8]) != 8'h00);
   endfunction

   function automatic logic m_take();
      return !reset && (m_intp() || (exc_req && !m_sr[1]));
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd8:    return m_bva;
         5'd9:    return m_count;
         5'd11:   return m_cmp;
         5'd12:   return m_sr;
         5'd13:   return {m_bd, 15'b0, m_ip(), 1'b0, m_code, 2'b00};
         5'd14:   return m_epc;
         5'd15:   return 32'h18373541;
         default: return 32'h0;
      endcase
   endfunction

   // One clock edge; the model applies the architectural rules to the inputs present at the edge.
   task automatic cyc();
      logic intp, take, wr, nti;
      intp = m_intp();
      take = m_take();
      wr   = wr_en && !take && !eret;
      @(posedge clk);
      if (reset) begin
         m_sr = '0; m_epc = '0; m_bva = '0; m_count = '0; m_cmp = '0;
         m_sw = '0; m_code = '0; m_bd = 0; m_ti = 0; m_hw = '0;
      end else begin
         nti = (wr && wr_addr == 5'd11) ? 1'b0 : (m_ti || (m_count == m_cmp));
         m_count = (wr && wr_addr == 5'd9) ? wdata : m_count + 32'd1;
         if (wr && wr_addr == 5'd11) m_cmp = wdata;
         m_ti = nti;
         m_hw = hw_int;
         if (take) begin
            m_sr[1] = 1'b1;
            m_code  = intp ? 5'd0 : exc_code;
            m_bd    = exc_bd;
            m_epc   = {exc_pc[31:2], 2'b00};
            if (!intp && (exc_code == 5'd4 || exc_code == 5'd5)) m_bva = exc_badvaddr;
         end else if (eret) begin
            m_sr[1] = 1'b0;
         end else if (wr) begin
            if (wr_addr == 5'd12) m_sr = wdata;
            if (wr_addr == 5'd13) m_sw = wdata[9:8];
            if (wr_addr == 5'd14) m_epc = wdata & ~32'h3;
         end
      end
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wdata = d;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [4:0]  addrs [5] = '{5'd12, 5'd13, 5'd14, 5'd9, 5'd15};
      logic [31:0] exps  [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h18373541};
      reset = 1'b1; exc_req = 1'b1;
      cyc();
      checks++;
      if (take_exc !== 1'b0) begin errors++; $display("FAIL reset_take got %b exp 0", take_exc); end
      cyc();
      reset = 1'b0; exc_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         rd_addr = addrs[i]; #1;
         checks++;
         if (rdata !== exps[i]) begin
            errors++; $display("FAIL reset_rd%0d got %h exp %h", addrs[i], rdata, exps[i]);
         end
      end
      mtc0(5'd11, 32'h8000_0000);  // park Compare far away so TI stays clear
   endtask

   task automatic test_interrupt();
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'h01; exc_pc = 32'h3008;
      cyc();
      checks++;
      if (take_exc !== 1'b1) begin errors++; $display("FAIL int_take got %b exp 1", take_exc); end
      cyc();
      rd_addr = 5'd13; #1; checks++;
      if (rdata !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got %h exp 00000400", rdata); end
      rd_addr = 5'd14; #1; checks++;
      if (rdata !== 32'h3008 || epc_out !== 32'h3008) begin
         errors++; $display("FAIL int_epc got %h/%h exp 00003008", rdata, epc_out);
      end
      rd_addr = 5'd12; #1; checks++;
      if (rdata !== 32'h0000_0403) begin errors++; $display("FAIL int_sr got %h exp 00000403", rdata); end
      hw_int = 6'h02;
      cyc();
      checks++;
      if (take_exc !== 1'b0) begin errors++; $display("FAIL int_masked got %b exp 0", take_exc); end
      eret = 1'b1; cyc(); eret = 1'b0;
      hw_int = 6'h00; cyc();
      checks++;
      if (take_exc !== m_take()) begin errors++; $display("FAIL int_after_eret got %b exp %b", take_exc, m_take()); end
   endtask

   task automatic test_exception();
      exc_req = 1'b1; exc_code = 5'd4; exc_bd = 1'b1; exc_pc = 32'h3010; exc_badvaddr = 32'h1001;
      #1; checks++;
      if (take_exc !== 1'b1) begin errors++; $display("FAIL exc_take got %b exp 1", take_exc); end
      cyc();
      exc_req = 1'b0; exc_bd = 1'b0;
      rd_addr = 5'd13; #1; checks++;
      if (rdata !== 32'h8000_0010) begin errors++; $display("FAIL exc_cause got %h exp 80000010", rdata); end
      rd_addr = 5'd14; #1; checks++;
      if (rdata !== 32'h3010) begin errors++; $display("FAIL exc_epc got %h exp 00003010", rdata); end
      rd_addr = 5'd8; #1; checks++;
      if (rdata !== 32'h1001) begin errors++; $display("FAIL exc_badva got %h exp 00001001", rdata); end
      eret = 1'b1; cyc(); eret = 1'b0;
      rd_addr = 5'd12; #1; checks++;
      if (rdata !== 32'h0000_0401) begin errors++; $display("FAIL exc_eret_sr got %h exp 00000401", rdata); end
   endtask

   task automatic test_timer();
      int n = 0;
      mtc0(5'd9, 32'd0);
      mtc0(5'd11, 32'd5);
      mtc0(5'd12, 32'h0000_8001);
      while (!take_exc && n < 20) begin
         checks++;
         if (take_exc !== m_take()) begin errors++; $display("FAIL tmr_wait got %b exp %b", take_exc, m_take()); end
         cyc(); n++;
      end
      checks++;
      if (take_exc !== 1'b1) begin errors++; $display("FAIL tmr_take got %b exp 1 after %0d cycles", take_exc, n); end
      rd_addr = 5'd9; #1; checks++;
      if (rdata !== 32'd6) begin errors++; $display("FAIL tmr_count got %0d exp 6", rdata); end
      cyc();
      rd_addr = 5'd13; #1; checks++;
      if (rdata !== 32'h0000_8000) begin errors++; $display("FAIL tmr_cause got %h exp 00008000", rdata); end
      mtc0(5'd11, 32'd100);
      #1; checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL tmr_ti_clear got %h exp 00000000", rdata); end
      eret = 1'b1; cyc(); eret = 1'b0;
      mtc0(5'd12, 32'h0);
   endtask

   task automatic test_wrap();
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd_addr = 5'd9; #1; checks++;
      if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre got %h exp ffffffff", rdata); end
      cyc(); checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 00000000", rdata); end
      mtc0(5'd9, 32'd7); checks++;
      if (rdata !== 32'd7) begin errors++; $display("FAIL wrap_write got %h exp 00000007", rdata); end
   endtask

   task automatic test_priority();
      mtc0(5'd12, 32'h0000_0401);
      hw_int = 6'h01; cyc();
      exc_req = 1'b1; exc_code = 5'd12; eret = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd12; wdata = 32'h0;
      #1; checks++;
      if (take_exc !== 1'b1) begin errors++; $display("FAIL prio_take got %b exp 1", take_exc); end
      cyc();
      exc_req = 1'b0; eret = 1'b0; wr_en = 1'b0;
      rd_addr = 5'd12; #1; checks++;
      if (rdata !== 32'h0000_0403) begin errors++; $display("FAIL prio_sr got %h exp 00000403", rdata); end
      rd_addr = 5'd13; #1; checks++;
      if (rdata !== 32'h0000_0400) begin errors++; $display("FAIL prio_cause got %h exp 00000400", rdata); end
      hw_int = 6'h00;
      mtc0(5'd12, 32'h0);
   endtask

   task automatic test_random();
      logic [4:0] amap [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
      for (int c = 0; c < 3000; c++) begin
         reset    = ($urandom_range(0, 299) == 0);
         rd_addr  = amap[$urandom_range(0, 7)];
         wr_en    = ($urandom_range(0, 3) == 0);
         wr_addr  = amap[$urandom_range(0, 7)];
         wdata    = $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom;
         if (wr_addr == 5'd12 && $urandom_range(0, 1) == 1) wdata = wdata & 32'h0000_FF01;
         if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom);
         exc_req  = ($urandom_range(0, 7) == 0);
         exc_code = 5'($urandom_range(0, 15));
         exc_bd   = 1'($urandom);
         exc_pc   = $urandom;
         exc_badvaddr = $urandom;
         eret     = ($urandom_range(0, 7) == 0);
         #1;
         checks++;
         if (take_exc !== m_take()) begin
            errors++; $display("FAIL rnd_take c%0d got %b exp %b", c, take_exc, m_take());
         end
         checks++;
         if (rdata !== m_read(rd_addr)) begin
            errors++; $display("FAIL rnd_rd%0d c%0d got %h exp %h", rd_addr, c, rdata, m_read(rd_addr));
         end
         checks++;
         if (epc_out !== m_epc) begin
            errors++; $display("FAIL rnd_epc c%0d got %h exp %h", c, epc_out, m_epc);
         end
         cyc();
      end
      reset = 1'b0; wr_en = 1'b0; exc_req = 1'b0; eret = 1'b0;
   endtask

   initial begin
      test_reset();
      test_interrupt();
      test_exception();
      test_timer();
      test_wrap();
      test_priority();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
